// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: ARM execute stage with operand forwarding, ALU, iterative shift-add multiplier
// and the EXE/MEM output register behind a valid/ready/stall/flush handshake.
module exe_stage_pipe #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 4,
  parameter int OFFS_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        exe_cmd,
  input  logic              s_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic [WIDTH-1:0]  val_rn,
  input  logic [WIDTH-1:0]  val_rm,
  input  logic [WIDTH-1:0]  val_2,
  input  logic [OFFS_W-1:0] imm_offs,
  input  logic [3:0]        sr,
  input  logic [1:0]        fwd_sel_rn,
  input  logic [1:0]        fwd_sel_rm,
  input  logic [WIDTH-1:0]  fwd_mem,
  input  logic [WIDTH-1:0]  fwd_wb,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [WIDTH-1:0]  alu_result,
  output logic [WIDTH-1:0]  br_addr,
  output logic [WIDTH-1:0]  val_rm_out,
  output logic [3:0]        status,
  output logic              status_wr,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DEST_W-1:0] dest
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  acc_q, mcand_q, mplier_q, br_q, rmo_q;
  logic [3:0]        sr_q;
  logic              s_q, wb_q, mr_q, mw_q, s_out_q;
  logic [DEST_W-1:0] dest_q;
  logic [WIDTH-1:0]  op_a, rm_f, b_op, res_d, offs_sh, br;
  logic [WIDTH:0]    sum;
  logic [3:0]        status_d, mul_status;
  logic              is_arith, is_sub, cin, ovf, known, is_mul, out_free, accept;
  assign op_a = fwd_sel_rn == 2'd1 ? fwd_mem : fwd_sel_rn == 2'd2 ? fwd_wb : val_rn;
  assign rm_f = fwd_sel_rm == 2'd1 ? fwd_mem : fwd_sel_rm == 2'd2 ? fwd_wb : val_rm;
  // Offset is sign-extended and pre-shifted by 2 in one step.
  genvar k;
  for (k = 0; k < WIDTH; k++) begin : g_offs
    if (k < 2) begin : g_lo
      assign offs_sh[k] = 1'b0;
    end else if (k - 2 < OFFS_W) begin : g_mid
      assign offs_sh[k] = imm_offs[k-2];
    end else begin : g_hi
      assign offs_sh[k] = imm_offs[OFFS_W-1];
    end
  end
  assign br         = pc_in + offs_sh;
  assign is_mul     = exe_cmd == OP_MUL;
  assign out_free   = !out_valid || !stall;
  assign in_ready   = state_q == S_IDLE && out_free && !flush;
  assign accept     = in_valid && in_ready;
  assign status_wr  = out_valid && s_out_q;
  assign mul_status = {acc_q[WIDTH-1], acc_q == '0, sr_q[1:0]};
  // Subtraction is a + ~b + carry_in, so carry out is directly NOT borrow.
  always_comb begin
    is_arith = exe_cmd inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC};
    is_sub   = exe_cmd inside {OP_SUB, OP_SBC};
    b_op     = is_sub ? ~val_2 : val_2;
    cin      = exe_cmd == OP_ADD ? 1'b0 : exe_cmd == OP_SUB ? 1'b1 : sr[1];
    sum      = {1'b0, op_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    ovf      = (op_a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    res_d    = '0;
    known    = 1'b1;
    case (exe_cmd)
      OP_MOV:                         res_d = val_2;
      OP_MVN:                         res_d = ~val_2;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: res_d = sum[WIDTH-1:0];
      OP_AND:                         res_d = op_a & val_2;
      OP_ORR:                         res_d = op_a | val_2;
      OP_EOR:                         res_d = op_a ^ val_2;
      default:                        known = 1'b0;
    endcase
    status_d = known ? {res_d[WIDTH-1], res_d == '0, is_arith ? sum[WIDTH] : sr[1],
                        is_arith ? ovf : sr[0]} : sr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      br_q       <= '0;
      rmo_q      <= '0;
      sr_q       <= '0;
      s_q        <= 1'b0;
      wb_q       <= 1'b0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
      dest_q     <= '0;
      out_valid  <= 1'b0;
      alu_result <= '0;
      br_addr    <= '0;
      val_rm_out <= '0;
      status     <= '0;
      s_out_q    <= 1'b0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      dest       <= '0;
    end else if (flush) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_free) out_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && is_mul) begin
            state_q  <= S_MUL;
            cnt_q    <= CW'(WIDTH);
            acc_q    <= '0;
            mcand_q  <= op_a;
            mplier_q <= rm_f;
            br_q     <= br;
            rmo_q    <= rm_f;
            sr_q     <= sr;
            s_q      <= s_in;
            wb_q     <= wb_en_in;
            mr_q     <= mem_r_en_in;
            mw_q     <= mem_w_en_in;
            dest_q   <= dest_in;
          end else if (accept) begin
            out_valid  <= 1'b1;
            alu_result <= res_d;
            br_addr    <= br;
            val_rm_out <= rm_f;
            status     <= status_d;
            s_out_q    <= s_in;
            wb_en      <= wb_en_in;
            mem_r_en   <= mem_r_en_in;
            mem_w_en   <= mem_w_en_in;
            dest       <= dest_in;
          end
        end
        S_MUL: begin
          acc_q    <= mplier_q[0] ? acc_q + mcand_q : acc_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_free) begin
            state_q    <= S_IDLE;
            out_valid  <= 1'b1;
            alu_result <= acc_q;
            br_addr    <= br_q;
            val_rm_out <= rmo_q;
            status     <= mul_status;
            s_out_q    <= s_q;
            wb_en      <= wb_q;
            mem_r_en   <= mr_q;
            mem_w_en   <= mw_q;
            dest       <= dest_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/exe_stage_pipe.md
Name: exe_stage_pipe

Overview:
- Parametrised execute stage for the ARM pipeline. Combines ALU execution, operand forwarding, branch-target computation and the EXE/MEM pipeline register in one block.
- Adds a multi-cycle iterative MUL, a valid/ready/stall handshake and a flush, so the hazard unit can stall or kill in-flight work.
- Sits between the ID/EXE register and the MEM stage.

Parameters:
- WIDTH, 32, datapath width of operands, results and PC (>=8, even).
- DEST_W, 4, register-index width.
- OFFS_W, 24, signed branch-offset width; offset is shifted left by 2 and sign-extended to WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- exe_cmd  in  4  op: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010.
- s_in  in  1  update flags.
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control, passed through.
- dest_in  in  DEST_W  destination register.
- pc_in  in  WIDTH  PC of the instruction.
- val_rn, val_rm  in  WIDTH  register-file operands.
- val_2  in  WIDTH  shifted/immediate second operand.
- imm_offs  in  OFFS_W  branch offset.
- sr  in  4  current NZCV.
- fwd_sel_rn, fwd_sel_rm  in  2  0 = register file, 1 = fwd_mem, 2 = fwd_wb, 3 = register file.
- fwd_mem, fwd_wb  in  WIDTH  forwarded values.
- stall  in  1  MEM stage cannot take output.
- flush  in  1  kill in-flight and held work.
- out_valid  out  1  outputs below are valid.
- alu_result, br_addr, val_rm_out  out  WIDTH.
- status  out  4  new NZCV.
- status_wr  out  1  equals out_valid & registered s.
- wb_en, mem_r_en, mem_w_en  out  1 each.
- dest  out  DEST_W.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0 except in_ready; in_ready = 1 the cycle after reset; FSM = IDLE; MUL counter = 0.
- Operand A: rn after forwarding mux. Operand B: val_2, or forwarded rm for MUL. val_rm_out = forwarded rm, used as store data.
- br_addr = pc_in + (sext(imm_offs) << 2), modulo 2^WIDTH.
- Output register may load when out_free = !out_valid | !stall.
- in_ready = (state == IDLE) & out_free & !flush.
- Accept = in_valid & in_ready.
- FSM states:
  - IDLE, non-MUL accept: result, flags, control and dest load into the output register at the accepting edge; out_valid = 1 next cycle (latency 1).
  - IDLE, MUL accept: capture operands and control; counter = WIDTH; go to MUL. out_valid drops to 0 at that edge unless still held by stall.
  - MUL: shift-add one multiplier bit per cycle, decrement counter. At counter 0 go to DONE.
  - DONE: when out_free, load the low WIDTH bits of the product into the output register, out_valid = 1, go to IDLE. Unstalled latency is WIDTH+1 edges from accept to out_valid.
- Stall: while stall & out_valid, every output holds bit-exact. A MUL in progress keeps iterating and waits in DONE.
- Flags, ADD/ADC: C = carry out of bit WIDTH-1; V = signed overflow. ADC adds sr.C.
- Flags, SUB/SBC: C = NOT borrow; SBC computes a - b - !sr.C; V = signed overflow.
- Flags, MOV/MVN/logic ops/MUL: N = result[WIDTH-1], Z = (result == 0); C and V copied from sr.
- Unknown exe_cmd: result 0, status = sr.
- Flush, effect at the next edge: out_valid = 0; FSM = IDLE; counter = 0; a held result is discarded.
- Flush priority: flush beats stall and beats in_valid; no accept occurs in a flush cycle.
- Reset mid-MUL: same effect as flush, plus all outputs cleared.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, s = 1 -> next cycle alu_result 0x80000000, status 1001, status_wr 1.
- SUB 5 - 5, s = 1 -> result 0, status 0110. Then SBC 0 - 0 with sr.C = 0 -> result 0xFFFFFFFF, status 1000.
- MUL, rn = 7, rm = 6 -> in_ready 0 for the next 33 cycles; out_valid rises exactly 33 edges after accept with alu_result 42; flags N = 0, Z = 0, C/V equal sr.
- fwd_sel_rn = 1, fwd_mem = 100, val_rn = 1, val_2 = 5, ADD -> 105. fwd_sel_rm = 2 on a store -> val_rm_out = fwd_wb.
- stall held 3 cycles after an ADD output -> outputs unchanged, in_ready 0. Release -> next instruction accepted the same cycle.
- flush at MUL cycle 10 -> out_valid stays 0, in_ready 1 the next cycle. pc_in 0x100 with imm_offs 0xFFFFFF -> br_addr 0x0FC.
